// File: rtl/gf180mcu_ocd_io_pkg.sv
// Shared state encoding and default parameter values for the pad-ring power sequencer.
package gf180mcu_ocd_io_pkg;

    localparam int NSEG_DEF  = 4;
    localparam int DLY_W_DEF = 8;
    localparam int DEB_DEF   = 4;
    localparam int TMO_DEF   = 255;

    typedef enum logic [2:0] {
        ST_OFF,
        ST_RAMP,
        ST_SETTLE,
        ST_ON,
        ST_DOWN,
        ST_FLT
    } pwr_state_t;

endpackage

// File: rtl/gf180mcu_ocd_io__pgdeb.sv
// Power-good conditioner: two-flop synchroniser followed by a debouncer that
// only accepts a new level after DEB consecutive identical synchronised samples.
module gf180mcu_ocd_io__pgdeb #(
    parameter int DEB = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic pg,
    output logic pgd
);

    localparam int CW = (DEB > 1) ? $clog2(DEB) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB - 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    // cnt tracks how many samples in a row have disagreed with pgd; it never exceeds DEB-1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= '0;
            cnt  <= '0;
            pgd  <= 1'b0;
        end else begin
            sync <= {sync[0], pg};
            if (sync[1] == pgd) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                pgd <= sync[1];
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/gf180mcu_ocd_io__pwrseq.sv
// Pad-ring power sequencer: enables NSEG segments one at a time on debounced
// power-good, powers them down in reverse order, and latches faults.
module gf180mcu_ocd_io__pwrseq
    import gf180mcu_ocd_io_pkg::*;
#(
    parameter int NSEG  = NSEG_DEF,
    parameter int DLY_W = DLY_W_DEF,
    parameter int DEB   = DEB_DEF,
    parameter int TMO   = TMO_DEF
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic [NSEG-1:0]  PG,
    input  logic [DLY_W-1:0] DLY,
    output logic [NSEG-1:0]  SEG_EN,
    output logic             READY,
    output logic             FAULT
);

    localparam int KW = (NSEG > 1) ? $clog2(NSEG) : 1;
    localparam int TW = (TMO > 1) ? $clog2(TMO + 1) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NSEG - 1);
    localparam logic [TW-1:0] T_LAST = TW'(TMO - 1);

    function automatic logic [DLY_W-1:0] dly_eff(input logic [DLY_W-1:0] d);
        return (d == '0) ? DLY_W'(1) : d;
    endfunction

    function automatic logic last_tick(input logic [DLY_W-1:0] d);
        return (d == '0) || (d == DLY_W'(1));
    endfunction

    pwr_state_t       state, state_n;
    logic [KW-1:0]    k, k_n;
    logic [DLY_W-1:0] dcnt, dcnt_n;
    logic [TW-1:0]    tcnt, tcnt_n;
    logic [NSEG-1:0]  seg_n;
    logic             ready_n, fault_n;
    logic [NSEG-1:0]  pgd;

    for (genvar i = 0; i < NSEG; i++) begin : g_deb
        gf180mcu_ocd_io__pgdeb #(.DEB(DEB)) u_deb (
            .clk (CLK),
            .rst (RST),
            .pg  (PG[i]),
            .pgd (pgd[i])
        );
    end

    always_comb begin
        state_n = state;
        k_n     = k;
        dcnt_n  = dcnt;
        tcnt_n  = tcnt;
        seg_n   = SEG_EN;
        ready_n = 1'b0;
        fault_n = FAULT;
        case (state)
            ST_OFF: begin
                fault_n = 1'b0;
                if (EN) begin
                    k_n      = '0;
                    seg_n    = '0;
                    seg_n[0] = 1'b1;
                    tcnt_n   = '0;
                    state_n  = ST_RAMP;
                end
            end
            // Timeout is tested before EN and PG so it wins any tie
            ST_RAMP: begin
                if (tcnt == T_LAST) begin
                    seg_n   = '0;
                    fault_n = 1'b1;
                    state_n = ST_FLT;
                end else if (!EN) begin
                    dcnt_n  = dly_eff(DLY);
                    state_n = ST_DOWN;
                end else if (pgd[k]) begin
                    dcnt_n  = dly_eff(DLY);
                    state_n = ST_SETTLE;
                end else begin
                    tcnt_n = tcnt + 1'b1;
                end
            end
            ST_SETTLE: begin
                if (!EN) begin
                    dcnt_n  = dly_eff(DLY);
                    state_n = ST_DOWN;
                end else if (last_tick(dcnt)) begin
                    dcnt_n = '0;
                    if (k == K_LAST) begin
                        state_n = ST_ON;
                    end else begin
                        k_n        = k + 1'b1;
                        seg_n[k_n] = 1'b1;
                        tcnt_n     = '0;
                        state_n    = ST_RAMP;
                    end
                end else begin
                    dcnt_n = dcnt - 1'b1;
                end
            end
            ST_ON: begin
                if (!(&pgd)) begin
                    seg_n   = '0;
                    fault_n = 1'b1;
                    state_n = ST_FLT;
                end else if (!EN) begin
                    dcnt_n  = dly_eff(DLY);
                    state_n = ST_DOWN;
                end else begin
                    ready_n = 1'b1;
                end
            end
            // k always points at the highest segment still enabled
            ST_DOWN: begin
                if (SEG_EN == '0) begin
                    state_n = ST_OFF;
                end else if (last_tick(dcnt)) begin
                    seg_n[k] = 1'b0;
                    if (k != '0) k_n = k - 1'b1;
                    dcnt_n   = dly_eff(DLY);
                end else begin
                    dcnt_n = dcnt - 1'b1;
                end
            end
            ST_FLT: begin
                seg_n = '0;
                if (!EN) begin
                    fault_n = 1'b0;
                    state_n = ST_OFF;
                end
            end
            default: begin
                seg_n   = '0;
                state_n = ST_OFF;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= ST_OFF;
            k      <= '0;
            dcnt   <= '0;
            tcnt   <= '0;
            SEG_EN <= '0;
            READY  <= 1'b0;
            FAULT  <= 1'b0;
        end else begin
            state  <= state_n;
            k      <= k_n;
            dcnt   <= dcnt_n;
            tcnt   <= tcnt_n;
            SEG_EN <= seg_n;
            READY  <= ready_n;
            FAULT  <= fault_n;
        end
    end

endmodule
